bp_fe_ras_ckpt: RTL and testbench
=================================

// Module: bp_fe_ras_ckpt
// PURPOSE
//  Multi-entry return address stack (RAS) for the FE PC generator. It holds up to
//  ras_els_p return targets and replaces the single-entry RAS in IF2.
//  Exports a compact checkpoint {count, tos} to carry in branch metadata.
//  On a backend redirect it restores that checkpoint and replays the redirecting
//  instruction's own call/return, so the stack is repaired after mispredictions.
// PARAMETERS
//  vaddr_width_p  39  virtual address width of return targets
//  ras_els_p      8   stack entries; >=2, need not be a power of two
//  ptr_width_lp   derived  `BSG_SAFE_CLOG2(ras_els_p)
//  cnt_width_lp   derived  `BSG_SAFE_CLOG2(ras_els_p+1)
//  ckpt_width_lp  derived  cnt_width_lp+ptr_width_lp
// PORTS
//  clk_i            in   1              clock
//  reset_i          in   1              synchronous active-high reset
//  call_i           in   1              IF2 call scanned: push addr_i
//  return_i         in   1              IF2 return scanned: pop
//  addr_i           in   vaddr_width_p  return address to push (fetch pc + 4/2)
//  tgt_o            out  vaddr_width_p  predicted return target, mem[tos]
//  v_o              out  1              stack non-empty (count != 0)
//  ckpt_o           out  ckpt_width_lp  {count, tos} before this cycle's update
//  restore_v_i      in   1              redirect: load restore_ckpt_i
//  restore_ckpt_i   in   ckpt_width_lp  checkpoint from redirect metadata
//  restore_call_i   in   1              redirecting instr is a call
//  restore_return_i in   1              redirecting instr is a return
//  restore_addr_i   in   vaddr_width_p  return address for restore_call_i
// BEHAVIOUR
//  - State: circular array mem[ras_els_p], tos pointer, saturating count.
//    All state is in flops.
//  - Reset: tos=0, count=0, mem all 0. Outputs v_o=0, tgt_o=0, ckpt_o=0.
//  - Reads are combinational: tgt_o=mem[tos], v_o=(count!=0).
//    ckpt_o={count,tos}. All are valid in the same cycle the state changes.
//  - Base state B: restore_ckpt_i if restore_v_i, else current {count,tos}.
//  - Operation op: {restore_call_i,restore_return_i,restore_addr_i} if
//    restore_v_i, else {call_i,return_i,addr_i}. When restore_v_i=1, the
//    IF2 call_i/return_i inputs are ignored that cycle (restore has priority).
//  - Push only: tos'=(tos==els-1)?0:tos+1; mem[tos']=addr.
//    count'=min(count+1, els). At full, the oldest entry is overwritten (wrap).
//  - Pop only, count>0: tos'=(tos==0)?els-1:tos-1; count'=count-1.
//  - Pop only, count==0: no change (underflow ignored).
//  - Push+pop together (coroutine jalr): mem[tos]=addr; tos unchanged.
//    count'=max(count,1).
//  - Neither: state = B, so a bare restore only reloads the pointers.
//  - Update latency: 1 cycle. The next cycle's tgt_o/v_o reflect the update.
//  - Restore is pointer-only. Entries overwritten by wrong-path pushes stay
//    corrupted. This is accepted; the BTB/override path corrects the target.
//  - restore_ckpt_i with tos>=els or count>els is illegal. Flag it with an
//    assertion; no RTL recovery is required.
//  - reset_i mid-operation: all state returns to reset values on the next edge.
//    Any call/return/restore in that cycle is discarded.
// TESTING (ras_els_p=4, vaddr_width_p=39)
//  1. Reset, then return_i=1 -> v_o=0, tgt_o=0, ckpt_o=0 unchanged.
//  2. Push 0x100, 0x200, 0x300 -> tgt_o=0x300, ckpt_o={3,3}.
//     Then pop -> tgt_o=0x200, ckpt_o={2,2}.
//  3. From reset, push 0x10..0x50 (5 calls) -> count=4, tgt_o=0x50.
//     Four pops -> tgt_o 0x40, 0x30, 0x20, then v_o=0.
//  4. Push 0xA0, then call_i=return_i=1 with addr 0xB0 -> tgt_o=0xB0, count 1.
//     Pop -> v_o=0.
//  5. Push A=0x1000, B=0x2000; save ckpt_o={2,2}. Pop x2, then push X=0x3000.
//     restore_v_i with {2,2} -> tgt_o=0x2000, v_o=1.
//     Pop -> tgt_o=0x3000 (corruption accepted).
//     Repeat with restore_call_i=1, addr 0x4000 -> tgt_o=0x4000, count 3.
//  6. Assert reset_i in the same cycle as call_i and restore_v_i -> next cycle
//     all state 0, v_o=0. Random push/pop/restore vs reference model: no mismatch.

Source files
------------

// File: rtl/bp_fe_ras_ckpt.sv
// Multi-entry return address stack with {count, tos} checkpoint export.
// A redirect reloads the checkpoint and replays the redirecting instruction's call/return.
module bp_fe_ras_ckpt #(
    parameter int vaddr_width_p = 39,
    parameter int ras_els_p     = 8,
    localparam int ptr_width_lp  = (ras_els_p <= 1) ? 1 : $clog2(ras_els_p),
    localparam int cnt_width_lp  = $clog2(ras_els_p + 1),
    localparam int ckpt_width_lp = cnt_width_lp + ptr_width_lp
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     call_i,
    input  logic                     return_i,
    input  logic [vaddr_width_p-1:0] addr_i,
    output logic [vaddr_width_p-1:0] tgt_o,
    output logic                     v_o,
    output logic [ckpt_width_lp-1:0] ckpt_o,
    input  logic                     restore_v_i,
    input  logic [ckpt_width_lp-1:0] restore_ckpt_i,
    input  logic                     restore_call_i,
    input  logic                     restore_return_i,
    input  logic [vaddr_width_p-1:0] restore_addr_i
);

    localparam logic [ptr_width_lp-1:0] tos_last_lp = ptr_width_lp'(ras_els_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_full_lp = cnt_width_lp'(ras_els_p);

    logic [vaddr_width_p-1:0] mem_q [ras_els_p];
    logic [vaddr_width_p-1:0] mem_d [ras_els_p];
    logic [ptr_width_lp-1:0]  tos_q, tos_d;
    logic [cnt_width_lp-1:0]  cnt_q, cnt_d;

    logic [ptr_width_lp-1:0]  base_tos;
    logic [cnt_width_lp-1:0]  base_cnt;
    logic                     op_push, op_pop;
    logic [vaddr_width_p-1:0] op_addr;

    assign tgt_o  = mem_q[tos_q];
    assign v_o    = (cnt_q != '0);
    assign ckpt_o = {cnt_q, tos_q};

    always_comb begin
        base_tos = restore_v_i ? restore_ckpt_i[ptr_width_lp-1:0] : tos_q;
        base_cnt = restore_v_i ? restore_ckpt_i[ckpt_width_lp-1:ptr_width_lp] : cnt_q;
        op_push  = restore_v_i ? restore_call_i   : call_i;
        op_pop   = restore_v_i ? restore_return_i : return_i;
        op_addr  = restore_v_i ? restore_addr_i   : addr_i;

        tos_d = base_tos;
        cnt_d = base_cnt;
        mem_d = mem_q;

        if (op_push && !op_pop) begin
            tos_d = (base_tos == tos_last_lp) ? '0 : base_tos + ptr_width_lp'(1);
            mem_d[tos_d] = op_addr;
            cnt_d = (base_cnt == cnt_full_lp) ? base_cnt : base_cnt + cnt_width_lp'(1);
        end else if (op_pop && !op_push) begin
            // Underflow leaves the base state untouched.
            if (base_cnt != '0) begin
                tos_d = (base_tos == '0) ? tos_last_lp : base_tos - ptr_width_lp'(1);
                cnt_d = base_cnt - cnt_width_lp'(1);
            end
        end else if (op_push && op_pop) begin
            mem_d[base_tos] = op_addr;
            if (base_cnt == '0) cnt_d = cnt_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tos_q <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < ras_els_p; i++) mem_q[i] <= '0;
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && restore_v_i) begin
            assert ((restore_ckpt_i[ptr_width_lp-1:0] <= tos_last_lp) &&
                    (restore_ckpt_i[ckpt_width_lp-1:ptr_width_lp] <= cnt_full_lp))
            else $error("bp_fe_ras_ckpt: illegal restore checkpoint 0x%0h", restore_ckpt_i);
        end
    end

endmodule

// File: tb/tb_bp_fe_ras_ckpt.sv
// Directed and random checks of bp_fe_ras_ckpt against a scoreboard fed by a behavioural stack model.
module tb_bp_fe_ras_ckpt;

    localparam int VW  = 39;
    localparam int ELS = 4;
    localparam int KW  = 5;

    logic          clk = 1'b0;
    logic          reset_i, call_i, return_i;
    logic [VW-1:0] addr_i, tgt_o;
    logic          v_o;
    logic [KW-1:0] ckpt_o;
    logic          restore_v_i, restore_call_i, restore_return_i;
    logic [KW-1:0] restore_ckpt_i;
    logic [VW-1:0] restore_addr_i;

    always #5 clk = ~clk;

    bp_fe_ras_ckpt #(.vaddr_width_p(VW), .ras_els_p(ELS)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .call_i          (call_i),
        .return_i        (return_i),
        .addr_i          (addr_i),
        .tgt_o           (tgt_o),
        .v_o             (v_o),
        .ckpt_o          (ckpt_o),
        .restore_v_i     (restore_v_i),
        .restore_ckpt_i  (restore_ckpt_i),
        .restore_call_i  (restore_call_i),
        .restore_return_i(restore_return_i),
        .restore_addr_i  (restore_addr_i)
    );

    typedef struct packed {
        logic [VW-1:0] tgt;
        logic          v;
        logic [KW-1:0] ckpt;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [VW-1:0] m_mem[ELS];
    int            m_tos, m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic call, input logic ret,
                              input logic [VW-1:0] addr, input logic rv,
                              input logic [KW-1:0] rck, input logic rcall,
                              input logic rret, input logic [VW-1:0] raddr);
        int bt, bc;
        logic psh, pp;
        logic [VW-1:0] a;
        exp_t e;
        if (rst) begin
            m_tos = 0;
            m_cnt = 0;
            for (int i = 0; i < ELS; i++) m_mem[i] = '0;
        end else begin
            bt  = rv ? int'(rck[1:0]) : m_tos;
            bc  = rv ? int'(rck[4:2]) : m_cnt;
            psh = rv ? rcall : call;
            pp  = rv ? rret  : ret;
            a   = rv ? raddr : addr;
            m_tos = bt;
            m_cnt = bc;
            if (psh && pp) begin
                m_mem[bt] = a;
                if (m_cnt < 1) m_cnt = 1;
            end else if (psh) begin
                m_tos = (bt + 1) % ELS;
                m_mem[m_tos] = a;
                if (m_cnt < ELS) m_cnt++;
            end else if (pp && bc > 0) begin
                m_tos = (bt + ELS - 1) % ELS;
                m_cnt--;
            end
        end
        e.tgt  = m_mem[m_tos];
        e.v    = (m_cnt != 0);
        e.ckpt = {3'(m_cnt), 2'(m_tos)};
        sb.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic call, input logic ret,
                         input logic [VW-1:0] addr, input logic rv,
                         input logic [KW-1:0] rck, input logic rcall,
                         input logic rret, input logic [VW-1:0] raddr);
        exp_t e;
        reset_i = rst; call_i = call; return_i = ret; addr_i = addr;
        restore_v_i = rv; restore_ckpt_i = rck; restore_call_i = rcall;
        restore_return_i = rret; restore_addr_i = raddr;
        model_step(rst, call, ret, addr, rv, rck, rcall, rret, raddr);
        @(posedge clk);
        #1;
        reset_i = 1'b0; call_i = 1'b0; return_i = 1'b0; addr_i = '0;
        restore_v_i = 1'b0; restore_ckpt_i = '0; restore_call_i = 1'b0;
        restore_return_i = 1'b0; restore_addr_i = '0;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_tgt", 64'(tgt_o), 64'(e.tgt));
            chk("sb_v", 64'(v_o), 64'(e.v));
            chk("sb_ckpt", 64'(ckpt_o), 64'(e.ckpt));
        end
    endtask

    task automatic push(input logic [VW-1:0] a);
        drive(1'b0, 1'b1, 1'b0, a, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic pop();
        drive(1'b0, 1'b0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic rst_step();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [KW-1:0] rck;
        int r;
        reset_i = 1'b1; call_i = 1'b0; return_i = 1'b0; addr_i = '0;
        restore_v_i = 1'b0; restore_ckpt_i = '0; restore_call_i = 1'b0;
        restore_return_i = 1'b0; restore_addr_i = '0;
        model_step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("reset_v", 64'(v_o), 64'd0);
        chk("reset_tgt", 64'(tgt_o), 64'd0);
        chk("reset_ckpt", 64'(ckpt_o), 64'd0);

        // Underflow on an empty stack
        pop();
        chk("underflow_v", 64'(v_o), 64'd0);
        chk("underflow_tgt", 64'(tgt_o), 64'd0);
        chk("underflow_ckpt", 64'(ckpt_o), 64'd0);

        // Basic push/pop
        push('h100); push('h200); push('h300);
        chk("push3_tgt", 64'(tgt_o), 64'h300);
        chk("push3_ckpt", 64'(ckpt_o), 64'h0F);
        pop();
        chk("pop1_tgt", 64'(tgt_o), 64'h200);
        chk("pop1_ckpt", 64'(ckpt_o), 64'h0A);

        // Overflow wraps and overwrites the oldest entry
        rst_step();
        push('h10); push('h20); push('h30); push('h40); push('h50);
        chk("ovf_cnt", 64'(ckpt_o[4:2]), 64'd4);
        chk("ovf_tgt", 64'(tgt_o), 64'h50);
        pop(); chk("ovf_pop1", 64'(tgt_o), 64'h40);
        pop(); chk("ovf_pop2", 64'(tgt_o), 64'h30);
        pop(); chk("ovf_pop3", 64'(tgt_o), 64'h20);
        pop(); chk("ovf_pop4_v", 64'(v_o), 64'd0);

        // Simultaneous call+return replaces top of stack
        rst_step();
        push('hA0);
        drive(1'b0, 1'b1, 1'b1, 'hB0, 1'b0, '0, 1'b0, 1'b0, '0);
        chk("cor_tgt", 64'(tgt_o), 64'hB0);
        chk("cor_cnt", 64'(ckpt_o[4:2]), 64'd1);
        pop();
        chk("cor_pop_v", 64'(v_o), 64'd0);

        // Checkpoint restore, pointer-only repair
        rst_step();
        push('h1000); push('h2000);
        chk("ck_saved", 64'(ckpt_o), 64'h0A);
        pop(); pop(); push('h3000);
        drive(1'b0, 1'b1, 1'b0, 'h77, 1'b1, 5'h0A, 1'b0, 1'b0, '0);
        chk("rst_tgt", 64'(tgt_o), 64'h2000);
        chk("rst_v", 64'(v_o), 64'd1);
        pop();
        chk("rst_corrupt", 64'(tgt_o), 64'h3000);
        drive(1'b0, 1'b0, 1'b1, '0, 1'b1, 5'h0A, 1'b1, 1'b0, 'h4000);
        chk("rcall_tgt", 64'(tgt_o), 64'h4000);
        chk("rcall_cnt", 64'(ckpt_o[4:2]), 64'd3);

        // Reset wins over call and restore in the same cycle
        drive(1'b1, 1'b1, 1'b0, 'h55, 1'b1, 5'h0A, 1'b1, 1'b0, 'h66);
        chk("rstmix_v", 64'(v_o), 64'd0);
        chk("rstmix_tgt", 64'(tgt_o), 64'd0);
        chk("rstmix_ckpt", 64'(ckpt_o), 64'd0);

        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            rck = {3'($urandom_range(0, ELS)), 2'($urandom_range(0, ELS - 1))};
            drive(r < 3, 1'($urandom), 1'($urandom), VW'($urandom),
                  (r >= 3) && (r < 18), rck, 1'($urandom), 1'($urandom), VW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
